uart_rx_frame_ctrl: RTL and testbench

- Receive-side UART frame controller. It sequences a local bit timer: restarts it on the start edge, samples at mid-bit, then reloads at full-bit intervals.
- Deserialises 8N1 frames (optionally with parity) into parallel bytes and delivers them on a valid/ready handshake.
- Sits between the pad-level rx line and the UART receive FIFO/consumer.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_bit_timer.sv | 27 ++
 rtl/uart_rx_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Optional parity support is selected in the controller with UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 10416;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Width of the bit timer: enough to hold CLKS_PER_BIT-1, never zero.
  function automatic int timer_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter used as the per-bit timer; tick is high while the count is zero.
// The counter parks at zero until the next load.
module uart_rx_bit_timer #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side UART frame controller: synchronises rx, sequences the bit timer and delivers words
// on a valid/ready handshake. Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy,
  output rx_state_e            dbg_state
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  // Handshake: a word is transferred in any cycle where rx_valid && rx_ready are both high;
  // rx_valid/rx_data hold until then, and rx_ready without rx_valid has no effect.

  logic rx_m, rx_s;
  rx_state_e state, state_n;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tick;
  logic [DATA_BITS-1:0] shift;
  logic [IW-1:0] bit_idx;
  logic shift_en, idx_clr, idx_inc;
  logic good_n, ferr_n;
  logic done_good, done_ferr;
`ifdef UART_RX_PARITY_EN
  logic par_cap, par_bad, perr_n, done_perr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_rx_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    good_n   = 1'b0;
    ferr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap  = 1'b0;
    perr_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
          state_n  = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            tmr_load = 1'b1;
            tmr_val  = FULL_LOAD;
            idx_clr  = 1'b1;
            state_n  = DATA;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = FULL_LOAD;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_cap  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = FULL_LOAD;
          state_n  = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) perr_n = 1'b1;
            else         good_n = 1'b1;
`else
            good_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Data bits arrive LSB first, so each one enters at the top and walks down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};
      if (idx_clr)      bit_idx <= '0;
      else if (idx_inc) bit_idx <= bit_idx + IW'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
    end else if (idx_clr) begin
      par_bad <= 1'b0;
    end else if (par_cap) begin
      par_bad <= (rx_s != (^shift));
    end
  end
`endif

  // Completion flags are registered with the state update; outputs load one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_good   <= 1'b0;
      done_ferr   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done_good   <= good_n;
      done_ferr   <= ferr_n;
      frame_err   <= done_ferr;
      overrun_err <= 1'b0;
      busy        <= (state != IDLE);
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_perr  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      done_perr  <= perr_n;
      parity_err <= done_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed scoreboard bench for uart_rx_frame_ctrl at 16 clocks per bit.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam logic [1:0] E_FRAME = 2'd0;
  localparam logic [1:0] E_OVR   = 2'd1;
  localparam logic [1:0] E_PAR   = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err, overrun_err, parity_err, busy;
  rx_state_e     dbg_state;

  int checks = 0;
  int failures = 0;
  logic [DB-1:0] exp_q[$];
  logic [1:0]    err_q[$];

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [DB-1:0] d, input logic par_b, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(stop_b);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
    send_frame_p(d, ^d, stop_b);
  endtask
`else
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask
`endif

  // Monitor: pops expected words on handshakes and expected error codes on pulses.
  logic          pv, pr, pfe, poe, ppe;
  logic [DB-1:0] pd;

  task automatic err_seen(input logic [1:0] code, input logic prev, input string name);
    if (prev) begin
      check({name, "_width"}, 32'(prev), 32'd0);
    end else if (err_q.size() == 0) begin
      check({name, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      check(name, 32'(code), 32'(err_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pd = '0;
      pfe = 1'b0; poe = 1'b0; ppe = 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
        else                   check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (pv && !pr) begin
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_data", 32'(rx_data), 32'(pd));
      end
      if (frame_err)   err_seen(E_FRAME, pfe, "frame_err");
      if (overrun_err) err_seen(E_OVR, poe, "overrun_err");
      if (parity_err)  err_seen(E_PAR, ppe, "parity_err");
      pv = rx_valid; pr = rx_ready; pd = rx_data;
      pfe = frame_err; poe = overrun_err; ppe = parity_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun_err", 32'(overrun_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick(4);

    // Normal frames with the consumer always ready
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(4);
    check("a5_busy_low", 32'(busy), 32'd0);
    check("a5_valid_one_cycle", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    tick(4);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    tick(4);

    // Start glitch: 4 low cycles is rejected at the mid-bit sample
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    check("glitch_busy_high", 32'(busy), 32'd1);
    tick(8);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_state", 32'(dbg_state), 32'(IDLE));

    // Stop bit low, line held low: one frame error, then wait in BREAK
    err_q.push_back(E_FRAME);
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("break_busy", 32'(busy), 32'd1);
    check("break_state", 32'(dbg_state), 32'(BREAK));
    check("break_no_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    tick(6);
    check("break_exit_busy", 32'(busy), 32'd0);

    // Overrun: second word dropped while the first is still pending
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(4);
    check("ovr_first_valid", 32'(rx_valid), 32'd1);
    check("ovr_first_data", 32'(rx_data), 32'h11);
    err_q.push_back(E_OVR);
    send_frame(8'h22, 1'b1);
    tick(4);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    tick(3);
    check("ovr_valid_cleared", 32'(rx_valid), 32'd0);

    // Reset in the middle of DATA for 0x55, then a clean 0x0F
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    tick(4);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the correct even-parity bit is 1
    err_q.push_back(E_PAR);
    send_frame_p(8'h07, 1'b0, 1'b1);
    tick(4);
    check("par_bad_no_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h07);
    send_frame_p(8'h07, 1'b1, 1'b1);
    tick(4);
`endif

    tick(10);
    check("words_outstanding", 32'(exp_q.size()), 32'd0);
    check("errors_outstanding", 32'(err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
